// File: rtl/alu_exec_seq.sv
// Command sequencer + ALU in front of an 8-entry register file with registered read data.
// Optional `FLAGS_EN adds zero/carry flag outputs updated by ADD/SUB/AND/OR/XOR.
module alu_exec_seq #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [WIDTH-1:0]  cmd_imm,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_register,
    output logic [WIDTH-1:0]  rf_data_in,
    input  logic [WIDTH-1:0]  rf_data_out,
    output logic              done,
    output logic [WIDTH-1:0]  result
`ifdef FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        CAP  = 3'd3,
        EXEC = 3'd4,
        WB   = 3'd5
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [2:0]          op_reg;
    logic [ADDR_W-1:0]   rd_reg;
    logic [ADDR_W-1:0]   rs1_reg;
    logic [ADDR_W-1:0]   rs2_reg;
    logic [WIDTH-1:0]    imm_reg;
    logic [WIDTH-1:0]    opa_reg;
    logic [WIDTH-1:0]    opb_reg;
    logic [WIDTH-1:0]    result_reg;
    logic [WIDTH-1:0]    alu_add;
    logic [WIDTH-1:0]    alu_res;
    logic                transfer;

    assign transfer = cmd_valid && cmd_ready;
    assign alu_add  = opa_reg + opb_reg;
    assign result   = result_reg;

    always_comb begin
        alu_res = result_reg;
        case (op_reg)
            OP_ADD:  alu_res = alu_add;
            OP_SUB:  alu_res = opa_reg - opb_reg;
            OP_AND:  alu_res = opa_reg & opb_reg;
            OP_OR:   alu_res = opa_reg | opb_reg;
            OP_XOR:  alu_res = opa_reg ^ opb_reg;
            OP_MOV:  alu_res = opa_reg;
            OP_LDI:  alu_res = imm_reg;
            default: alu_res = result_reg;
        endcase
    end

`ifdef FLAGS_EN
    logic alu_c;

    // A truncated sum smaller than an addend means the add wrapped.
    always_comb begin
        alu_c = 1'b0;
        if (op_reg == OP_ADD) begin
            alu_c = (alu_add < opa_reg);
        end else if (op_reg == OP_SUB) begin
            alu_c = (opa_reg < opb_reg);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            rd_reg     <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            imm_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
`ifdef FLAGS_EN
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (transfer) begin
                op_reg  <= cmd_op;
                rd_reg  <= cmd_rd;
                rs1_reg <= cmd_rs1;
                rs2_reg <= cmd_rs2;
                imm_reg <= cmd_imm;
            end
            // Read data trails the request by one cycle: rs1 arrives in RD_B, rs2 in CAP.
            if (state_reg == RD_B) begin
                opa_reg <= rf_data_out;
            end
            if (state_reg == CAP) begin
                opb_reg <= rf_data_out;
            end
            if (state_reg == EXEC && op_reg != OP_NOP) begin
                result_reg <= alu_res;
            end
`ifdef FLAGS_EN
            if (state_reg == EXEC && op_reg < OP_MOV) begin
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
            end
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        rf_rw       = 1'b0;
        rf_register = '0;
        rf_data_in  = '0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = (cmd_op == OP_LDI || cmd_op == OP_NOP) ? EXEC : RD_A;
                end
            end
            RD_A: begin
                rf_register = rs1_reg;
                state_next  = RD_B;
            end
            RD_B: begin
                rf_register = rs2_reg;
                state_next  = CAP;
            end
            CAP: begin
                state_next = EXEC;
            end
            EXEC: begin
                state_next = WB;
            end
            WB: begin
                done = 1'b1;
                if (op_reg != OP_NOP) begin
                    rf_rw       = 1'b1;
                    rf_register = rd_reg;
                    rf_data_in  = result_reg;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
